// File: rtl/split_fifo_pkg.sv
// Shared widths and the merged-word type for the split FIFO read path.
package split_fifo_pkg;

  localparam int unsigned W1_DEF = 18;
  localparam int unsigned W2_DEF = 9;
  localparam int unsigned DW     = W1_DEF + W2_DEF;

  typedef logic [DW-1:0] word_t;

  // Half 2 occupies the upper bits of the merged word.
  function automatic word_t merge_word(input logic [W1_DEF-1:0] d1,
                                       input logic [W2_DEF-1:0] d2);
    return {d2, d1};
  endfunction

endpackage

// File: rtl/split_fifo_drain_buf.sv
// Two-entry FIFO-ordered holding buffer; head is always presented on dout_o.
module split_fifo_drain_buf #(
  parameter int unsigned DW = 27
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_i,
  input  logic [DW-1:0] din_i,
  input  logic          rd_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          rd_eff;

  assign rd_eff  = rd_i & (count_q != 2'd0);
  assign dout_o  = head_q;
  assign count_o = count_q;

  // Next-state: shift tail into head on read, append on write.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({wr_i, rd_eff})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din_i;
        end else begin
          head_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The issue logic upstream must never push into a full buffer.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wr_i && !rd_eff && count_q == 2'd2));

endmodule

// File: rtl/split_fifo_drain.sv
// Drain controller for a split (W1 + W2) synchronous FIFO: paired reads,
// latency absorption, skew monitoring and error-event counting.
module split_fifo_drain
  import split_fifo_pkg::*;
#(
  parameter int unsigned W1        = W1_DEF,
  parameter int unsigned W2        = W2_DEF,
  parameter int unsigned SKEW_MAX  = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clock0,
  input  logic                 rst_ptr,
  input  logic                 empty1,
  input  logic                 empty2,
  input  logic [W1-1:0]        dout1,
  input  logic [W2-1:0]        dout2,
  input  logic                 underrun1,
  input  logic                 underrun2,
  input  logic                 overrun1,
  input  logic                 overrun2,
  output logic                 re1,
  output logic                 re2,
  output logic [W1+W2-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 desync,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           occupancy
);

  localparam int unsigned MW = W1 + W2;
  localparam int unsigned SW = $clog2(SKEW_MAX + 1);
  localparam logic [SW:0] SKEW_LIM = (SW+1)'(SKEW_MAX);

  logic                 pop, issue;
  logic [1:0]           buf_cnt;
  logic [2:0]           committed;
  logic                 inflight_q, inflight_d;
  logic [SW-1:0]        skew_q, skew_d;
  logic [SW:0]          skew_inc;
  logic                 desync_q, desync_d;
  logic                 err_any, err_prev_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign m_valid   = (buf_cnt != 2'd0);
  assign pop       = m_valid & m_ready;
  // Words that will occupy the buffer after this edge, before any new issue.
  assign committed = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = !rst_ptr & !empty1 & !empty2 & !desync_q & (committed < 3'd2);
  assign re1       = issue;
  assign re2       = issue;
  assign occupancy = buf_cnt;
  assign desync    = desync_q;
  assign err_cnt   = err_cnt_q;
  assign err_any   = underrun1 | underrun2 | overrun1 | overrun2;
  assign skew_inc  = {1'b0, skew_q} + {{SW{1'b0}}, 1'b1};

  split_fifo_drain_buf #(.DW(MW)) u_buf (
    .clk_i   (clock0),
    .rst_i   (rst_ptr),
    .wr_i    (inflight_q),
    .din_i   ({dout2, dout1}),
    .rd_i    (pop),
    .dout_o  (m_data),
    .count_o (buf_cnt)
  );

  // Next-state for inflight tracking, skew/desync and the error counter.
  always_comb begin
    inflight_d = issue;
    skew_d     = skew_q;
    desync_d   = desync_q;
    err_cnt_d  = err_cnt_q;
    if (empty1 != empty2) begin
      if (skew_inc <= SKEW_LIM) skew_d = skew_inc[SW-1:0];
      if (skew_inc >= SKEW_LIM) desync_d = 1'b1;
    end else begin
      skew_d = '0;
    end
    if (err_any && !err_prev_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock0) begin
    if (rst_ptr) begin
      inflight_q <= 1'b0;
      skew_q     <= '0;
      desync_q   <= 1'b0;
      err_prev_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      skew_q     <= skew_d;
      desync_q   <= desync_d;
      err_prev_q <= err_any;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_split_fifo_drain.sv
// Scoreboard bench for split_fifo_drain with a behavioural split-FIFO model.
module tb_split_fifo_drain;
  import split_fifo_pkg::*;

  logic        clock0 = 1'b0;
  logic        rst_ptr = 1'b1;
  logic        empty1, empty2;
  logic [17:0] dout1;
  logic [8:0]  dout2;
  logic        underrun1 = 0, underrun2 = 0, overrun1 = 0, overrun2 = 0;
  logic        re1, re2;
  word_t       m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        desync;
  logic [7:0]  err_cnt;
  logic [1:0]  occupancy;

  always #5 clock0 = ~clock0;

  split_fifo_drain #(.W1(18), .W2(9), .SKEW_MAX(4), .ERR_CNT_W(8)) dut (
    .clock0(clock0), .rst_ptr(rst_ptr), .empty1(empty1), .empty2(empty2),
    .dout1(dout1), .dout2(dout2), .underrun1(underrun1), .underrun2(underrun2),
    .overrun1(overrun1), .overrun2(overrun2), .re1(re1), .re2(re2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .desync(desync),
    .err_cnt(err_cnt), .occupancy(occupancy)
  );

  // Split FIFO model: registered read data, empty from pointer compare.
  logic [17:0] mem1 [256];
  logic [8:0]  mem2 [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underruns = 0;
  logic ovr = 1'b0, e1_ovr = 1'b1, e2_ovr = 1'b1;

  assign empty1 = ovr ? e1_ovr : (rd_ptr == wr_ptr);
  assign empty2 = ovr ? e2_ovr : (rd_ptr == wr_ptr);

  always @(posedge clock0) begin
    if (re1 || re2) begin
      if (rd_ptr == wr_ptr) underruns++;
      else begin
        dout1  <= mem1[rd_ptr[7:0]];
        dout2  <= mem2[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  word_t exp_q[$];
  int    checks = 0, failures = 0;
  bit    done = 0;
  int    cyc = 0, first_re = -1, first_val = -1, last_pop = 0, pops = 0, re_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  task automatic load(input int n, input int seed, input bit expect_out);
    logic [17:0] d1;
    logic [8:0]  d2;
    for (int i = 0; i < n; i++) begin
      d1 = 18'((seed + i) * 4099 + 17);
      d2 = 9'((seed + i) * 37 + 3);
      mem1[wr_ptr[7:0]] = d1;
      mem2[wr_ptr[7:0]] = d2;
      wr_ptr++;
      if (expect_out) exp_q.push_back(merge_word(d1, d2));
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    word_t e;
    word_t held = '0;
    bit    stall_prev = 0;
    while (!done) begin
      @(negedge clock0);
      cyc++;
      if (rst_ptr) begin
        stall_prev = 0;
      end else begin
        chk("re_pair", 32'(re1), 32'(re2));
        chk("occ_max", 32'(occupancy > 2'd2), 32'd0);
        if (re1) begin
          re_cnt++;
          if (first_re < 0) first_re = cyc;
        end
        if (m_valid && first_val < 0) first_val = cyc;
        if (stall_prev) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(held));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("data", 32'(m_data), 32'(e));
          end
          pops++;
          last_pop = cyc;
        end
        stall_prev = m_valid && !m_ready;
        held = m_data;
      end
    end
  endtask

  task automatic stimulus();
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state
    rst_ptr = 1; m_ready = 1;
    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_desync", 32'(desync), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_re", 32'(re1), 32'd0);
    rst_ptr = 0;
    tick();

    // Streaming, consumer always ready
    load(50, 0, 1);
    wait_drain("stream", 200);
    repeat (3) tick();
    chk("stream_reads", 32'(re_cnt), 32'd50);
    chk("stream_pops", 32'(pops), 32'd50);
    chk("first_latency", 32'(first_val - first_re), 32'd2);
    chk("back_to_back", 32'(last_pop - first_val), 32'd49);
    chk("stream_underrun", 32'(underruns), 32'd0);

    // Back-pressure pattern 1,0,0,1
    load(50, 100, 1);
    for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
      m_ready = pat[k % 4];
      tick();
    end
    m_ready = 1;
    wait_drain("stall", 20);
    repeat (3) tick();
    chk("stall_reads", 32'(re_cnt), 32'd100);
    chk("stall_pops", 32'(pops), 32'd100);

    // Skew: buffer two words, then exercise the desync threshold
    m_ready = 0;
    load(2, 200, 1);
    repeat (4) tick();
    chk("buffered_two", 32'(occupancy), 32'd2);
    ovr = 1; e1_ovr = 0; e2_ovr = 1;
    repeat (3) tick();
    e1_ovr = 1;
    tick();
    chk("skew3_desync", 32'(desync), 32'd0);
    e1_ovr = 0;
    repeat (3) tick();
    chk("skew_pre_desync", 32'(desync), 32'd0);
    tick();
    chk("skew4_desync", 32'(desync), 32'd1);
    e1_ovr = 0; e2_ovr = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("desync_no_re", 32'(re1), 32'd0);
    end
    chk("desync_occ", 32'(occupancy), 32'd2);
    m_ready = 1;
    wait_drain("desync", 20);
    ovr = 0; e1_ovr = 1; e2_ovr = 1;
    chk("desync_sticky", 32'(desync), 32'd1);
    chk("skew_underrun", 32'(underruns), 32'd0);

    // Error counter
    rst_ptr = 1;
    repeat (2) tick();
    rst_ptr = 0;
    chk("desync_cleared", 32'(desync), 32'd0);
    overrun1 = 1; tick();
    overrun1 = 0; tick();
    underrun2 = 1; repeat (3) tick();
    underrun2 = 0; tick();
    chk("err_two", 32'(err_cnt), 32'd2);
    repeat (253) begin overrun2 = 1; tick(); overrun2 = 0; tick(); end
    chk("err_at_max", 32'(err_cnt), 32'd255);
    repeat (47) begin underrun1 = 1; tick(); underrun1 = 0; tick(); end
    chk("err_saturated", 32'(err_cnt), 32'd255);

    // Mid-operation reset with one buffered and one inflight word
    m_ready = 0;
    load(2, 300, 0);
    tick();
    tick();
    chk("pre_rst_occ", 32'(occupancy), 32'd1);
    rst_ptr = 1;
    tick();
    chk("flush_valid", 32'(m_valid), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_err", 32'(err_cnt), 32'd0);
    chk("flush_data", 32'(m_data), 32'd0);
    rst_ptr = 0;
    m_ready = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("flush_no_emit", 32'(m_valid), 32'd0);
    end
    chk("final_underrun", 32'(underruns), 32'd0);
    done = 1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
